// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences memory, ALU and datapath strobes.
// Optional feature macro: MC_CTRL_ADDI_EN adds the ADDIEX/ADDIWB path for add-immediate.
module mc_main_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_c,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_illegal
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWR  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9
`ifdef MC_CTRL_ADDI_EN
    ,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
`endif
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (i_op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MC_CTRL_ADDI_EN
      OP_ADDI: op_legal = 1'b1;
`else
      OP_ADDI: op_legal = 1'b0;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = i_mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = ST_ADDIEX;
`endif
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (i_op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  state_d = i_mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = i_mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_ALUWB;
`ifdef MC_CTRL_ADDI_EN
      ST_ADDIEX: state_d = ST_ADDIWB;
`endif
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  // Moore decode; only the FETCH write strobes look at i_mem_ready. Reset masks everything.
  always_comb begin
    o_pc_write   = 1'b0;
    o_pc_write_c = 1'b0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_dst    = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_pc_source  = 2'b00;
    o_illegal    = 1'b0;
    if (!i_reset) begin
      case (state_q)
        ST_FETCH: begin
          o_mem_read  = 1'b1;
          o_alu_src_b = 2'b01;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        ST_DECODE: begin
          o_alu_src_b = 2'b11;
          o_illegal   = ~op_legal;
        end
        ST_MEMADR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
        end
        ST_MEMRD: begin
          o_mem_read = 1'b1;
          o_iord     = 1'b1;
        end
        ST_MEMWR: begin
          o_mem_write = 1'b1;
          o_iord      = 1'b1;
        end
        ST_MEMWB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
        end
        ST_EXEC: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = 2'b10;
        end
        ST_ALUWB: begin
          o_reg_write = 1'b1;
          o_reg_dst   = 1'b1;
        end
        ST_BRANCH: begin
          o_alu_src_a  = 1'b1;
          o_alu_op     = 2'b01;
          o_pc_write_c = 1'b1;
          o_pc_source  = 2'b01;
        end
        ST_JUMP: begin
          o_pc_write  = 1'b1;
          o_pc_source = 2'b10;
        end
`ifdef MC_CTRL_ADDI_EN
        ST_ADDIEX: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
        end
        ST_ADDIWB: begin
          o_reg_write = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: a step-list model expands each instruction into
// per-cycle expected strobes; a negedge monitor pops and compares every cycle.
module tb_mc_main_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [5:0] i_op = 6'h00;
  logic       i_mem_ready = 1'b0;
  logic       o_pc_write, o_pc_write_c, o_iord, o_mem_read, o_mem_write, o_ir_write;
  logic       o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_illegal;
  logic [1:0] o_alu_src_b, o_alu_op, o_pc_source;

  always #5 i_clk = ~i_clk;

  mc_main_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_op(i_op), .i_mem_ready(i_mem_ready),
    .o_pc_write(o_pc_write), .o_pc_write_c(o_pc_write_c), .o_iord(o_iord),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_ir_write(o_ir_write),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_dst(o_reg_dst), .o_reg_write(o_reg_write),
    .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op),
    .o_pc_source(o_pc_source), .o_illegal(o_illegal)
  );

`ifdef MC_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  // {pc_write, pc_write_c, iord, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2], illegal}
  logic [16:0] act;
  assign act = {o_pc_write, o_pc_write_c, o_iord, o_mem_read, o_mem_write, o_ir_write,
                o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_alu_src_b,
                o_alu_op, o_pc_source, o_illegal};

  typedef struct {
    bit          rst;
    bit          rdy;
    logic [5:0]  op;
    string       name;
    logic [16:0] exp;
  } cyc_t;

  cyc_t plan[$];
  cyc_t exp_q[$];
  cyc_t mon_item;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_instr = 0;

  function automatic logic [16:0] mk(input bit pcw, input bit pcwc, input bit iord,
                                     input bit mr, input bit mw, input bit irw,
                                     input bit m2r, input bit rdst, input bit rw,
                                     input bit sa, input bit [1:0] sb, input bit [1:0] aop,
                                     input bit [1:0] psrc, input bit ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, psrc, ill};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
           (op == 6'h02) || (ADDI_EN && op == 6'h08);
  endfunction

  // What the datapath must see during one step of an instruction.
  function automatic logic [16:0] step_out(input string s, input bit rdy, input bit ill);
    case (s)
      "FETCH":  return mk(rdy, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      "DECODE": return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, ill);
      "MEMADR": return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      "MEMRD":  return mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      "MEMWR":  return mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      "MEMWB":  return mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      "EXEC":   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      "ALUWB":  return mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      "BRANCH": return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      "JUMP":   return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
      "ADDIEX": return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      "ADDIWB": return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      default:  return 17'h0;
    endcase
  endfunction

  task automatic add_cycle(input bit rst, input bit rdy, input logic [5:0] op,
                           input string name, input logic [16:0] exp);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.op = op; c.name = name; c.exp = exp;
    plan.push_back(c);
  endtask

  // fw/mw = wait cycles in FETCH / data-memory step; rst_at = cycle index for reset (-1 none).
  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw, input int rst_at);
    string      steps[$];
    int         c;
    int         waits;
    bit         mem_step;
    bit         rdy;
    logic [5:0] opv;
    steps = '{"FETCH", "DECODE"};
    case (op)
      6'h23: begin steps.push_back("MEMADR"); steps.push_back("MEMRD"); steps.push_back("MEMWB"); end
      6'h2B: begin steps.push_back("MEMADR"); steps.push_back("MEMWR"); end
      6'h00: begin steps.push_back("EXEC"); steps.push_back("ALUWB"); end
      6'h04: steps.push_back("BRANCH");
      6'h02: steps.push_back("JUMP");
      6'h08: if (ADDI_EN) begin steps.push_back("ADDIEX"); steps.push_back("ADDIWB"); end
      default: ;
    endcase
    n_instr++;
    $display("[TB] instr %0d: op=%h fetch_wait=%0d mem_wait=%0d reset_at=%0d",
             n_instr, op, fw, mw, rst_at);
    c = 0;
    foreach (steps[i]) begin
      mem_step = (steps[i] == "FETCH") || (steps[i] == "MEMRD") || (steps[i] == "MEMWR");
      waits = (steps[i] == "FETCH") ? fw : (mem_step ? mw : 0);
      for (int w = 0; w <= waits; w++) begin
        rdy = mem_step ? (w == waits) : 1'($urandom_range(0, 1));
        opv = (steps[i] == "FETCH") ? 6'($urandom) : op;
        if (c == rst_at) begin
          add_cycle(1'b1, 1'($urandom_range(0, 1)), opv, "RESET", 17'h0);
          return;
        end
        add_cycle(1'b0, rdy, opv, steps[i], step_out(steps[i], rdy, !is_legal(op)));
        c++;
      end
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 6'h00;
      1: return 6'h23;
      2: return 6'h2B;
      3: return 6'h04;
      4: return 6'h02;
      5: return 6'h08;
      default: return 6'($urandom);
    endcase
  endfunction

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      mon_item = exp_q.pop_front();
      n_tests++;
      if (act !== mon_item.exp) begin
        n_fail++;
        $display("FAIL %s (op=%h rdy=%0d): got %h, expected %h",
                 mon_item.name, mon_item.op, mon_item.rdy, act, mon_item.exp);
      end
    end
  end

  initial begin
    int lim;
    // Reset held two cycles with memory ready, then directed cases, then random traffic.
    add_cycle(1'b1, 1'b1, 6'h00, "RESET", 17'h0);
    add_cycle(1'b1, 1'b1, 6'h00, "RESET", 17'h0);
    gen_instr(6'h23, 0, 0, -1);
    gen_instr(6'h2B, 0, 3, -1);
    gen_instr(6'h04, 0, 0, -1);
    gen_instr(6'h3F, 0, 0, -1);
    gen_instr(6'h08, 0, 0, -1);
    gen_instr(6'h00, 1, 0, -1);
    gen_instr(6'h02, 0, 0, -1);
    gen_instr(6'h23, 0, 2, 3);
    gen_instr(6'h23, 0, 0, -1);
    for (int k = 0; k < 200; k++) begin
      gen_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    foreach (plan[i]) begin
      @(posedge i_clk);
      #1;
      i_reset     = plan[i].rst;
      i_mem_ready = plan[i].rdy;
      i_op        = plan[i].op;
      exp_q.push_back(plan[i]);
    end

    lim = 0;
    while (exp_q.size() > 0 && lim < 10) begin
      @(posedge i_clk);
      lim++;
    end
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
